// File: rtl/reg_read_stage.sv
// ---------------------------------------------------------------------------
// reg_read_stage
//
// Register-read stage for a dual-issue pipeline. It holds a 32x32 register
// file with two write ports (wb0, wb1) and four read ports. Each accepted
// instruction pair is captured into an output register, together with its
// operand values. The outputs feed exe1 and the forwarding unit.
//
// Ports
//   clk, rstn                   clock, synchronous active-low reset
//   in_valid / in_ready         handshake with decode
//   in_en*, in_we*, in_r*, in_pc*  per-slot instruction fields from decode
//   wb0_* / wb1_*               writeback ports; wb1 wins on a collision
//   flush                       squashes the held pair and the incoming pair
//   out_valid / out_ready       handshake with exe1
//   eu*_en/_we/_rj/_rk/_rd/_pc  registered per-slot fields
//   data00, data01              operand values for eu0_rj and eu0_rk
//   data10, data11              operand values for eu1_rj and eu1_rk
// ---------------------------------------------------------------------------
module reg_read_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_en0,
  input  logic        in_en1,
  input  logic [4:0]  in_rj0,
  input  logic [4:0]  in_rk0,
  input  logic [4:0]  in_rd0,
  input  logic [4:0]  in_rj1,
  input  logic [4:0]  in_rk1,
  input  logic [4:0]  in_rd1,
  input  logic        in_we0,
  input  logic        in_we1,
  input  logic [31:0] in_pc0,
  input  logic [31:0] in_pc1,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        eu0_en,
  output logic        eu1_en,
  output logic        eu0_we,
  output logic        eu1_we,
  output logic [4:0]  eu0_rj,
  output logic [4:0]  eu0_rk,
  output logic [4:0]  eu1_rj,
  output logic [4:0]  eu1_rk,
  output logic [4:0]  eu0_rd,
  output logic [4:0]  eu1_rd,
  output logic [31:0] data00,
  output logic [31:0] data01,
  output logic [31:0] data10,
  output logic [31:0] data11,
  output logic [31:0] eu0_pc,
  output logic [31:0] eu1_pc
);

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        out_valid_q, out_valid_d;
  logic        eu0_en_q, eu0_en_d, eu1_en_q, eu1_en_d;
  logic        eu0_we_q, eu0_we_d, eu1_we_q, eu1_we_d;
  logic [4:0]  eu0_rj_q, eu0_rj_d, eu0_rk_q, eu0_rk_d, eu0_rd_q, eu0_rd_d;
  logic [4:0]  eu1_rj_q, eu1_rj_d, eu1_rk_q, eu1_rk_d, eu1_rd_q, eu1_rd_d;
  logic [31:0] data00_q, data00_d, data01_q, data01_d;
  logic [31:0] data10_q, data10_d, data11_q, data11_d;
  logic [31:0] eu0_pc_q, eu0_pc_d, eu1_pc_q, eu1_pc_d;

  logic        accept;
  logic        hold;

  // Read with same-cycle write-through; wb1 is the younger write and wins.
  function automatic logic [31:0] wt_read(input logic [4:0] idx);
    logic [31:0] val;
    if (idx == 5'd0)                    val = 32'd0;
    else if (wb1_en && wb1_rd == idx)   val = wb1_data;
    else if (wb0_en && wb0_rd == idx)   val = wb0_data;
    else                                val = rf_q[idx];
    return val;
  endfunction

  // Refresh a held operand if its register is being written back now.
  function automatic logic [31:0] snoop(input logic [4:0]  idx,
                                        input logic [31:0] cur);
    logic [31:0] val;
    if (idx == 5'd0)                    val = 32'd0;
    else if (wb1_en && wb1_rd == idx)   val = wb1_data;
    else if (wb0_en && wb0_rd == idx)   val = wb0_data;
    else                                val = cur;
    return val;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign hold     = out_valid_q && !out_ready;

  // Register file update: wb1 applied last so it wins on a collision.
  // Writes still commit during flush.
  always_comb begin
    for (int i = 0; i < 32; i++) rf_d[i] = rf_q[i];
    if (wb0_en && wb0_rd != 5'd0) rf_d[wb0_rd] = wb0_data;
    if (wb1_en && wb1_rd != 5'd0) rf_d[wb1_rd] = wb1_data;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    eu0_en_d = eu0_en_q;  eu1_en_d = eu1_en_q;
    eu0_we_d = eu0_we_q;  eu1_we_d = eu1_we_q;
    eu0_rj_d = eu0_rj_q;  eu0_rk_d = eu0_rk_q;  eu0_rd_d = eu0_rd_q;
    eu1_rj_d = eu1_rj_q;  eu1_rk_d = eu1_rk_q;  eu1_rd_d = eu1_rd_q;
    data00_d = data00_q;  data01_d = data01_q;
    data10_d = data10_q;  data11_d = data11_q;
    eu0_pc_d = eu0_pc_q;  eu1_pc_d = eu1_pc_q;

    // Flush dominates both a new accept and a drain by exe1.
    if (flush)                     out_valid_d = 1'b0;
    else if (accept)               out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      eu0_en_d = in_en0;  eu1_en_d = in_en1;
      eu0_we_d = in_we0;  eu1_we_d = in_we1;
      eu0_rj_d = in_rj0;  eu0_rk_d = in_rk0;  eu0_rd_d = in_rd0;
      eu1_rj_d = in_rj1;  eu1_rk_d = in_rk1;  eu1_rd_d = in_rd1;
      data00_d = wt_read(in_rj0);
      data01_d = wt_read(in_rk0);
      data10_d = wt_read(in_rj1);
      data11_d = wt_read(in_rk1);
      eu0_pc_d = in_pc0;  eu1_pc_d = in_pc1;
    end else if (hold) begin
      // Stalled pair: keep operands coherent with writebacks landing now.
      data00_d = snoop(eu0_rj_q, data00_q);
      data01_d = snoop(eu0_rk_q, data01_q);
      data10_d = snoop(eu1_rj_q, data10_q);
      data11_d = snoop(eu1_rk_q, data11_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      out_valid_q <= 1'b0;
      eu0_en_q <= 1'b0;  eu1_en_q <= 1'b0;
      eu0_we_q <= 1'b0;  eu1_we_q <= 1'b0;
      eu0_rj_q <= 5'd0;  eu0_rk_q <= 5'd0;  eu0_rd_q <= 5'd0;
      eu1_rj_q <= 5'd0;  eu1_rk_q <= 5'd0;  eu1_rd_q <= 5'd0;
      data00_q <= 32'd0; data01_q <= 32'd0;
      data10_q <= 32'd0; data11_q <= 32'd0;
      eu0_pc_q <= 32'd0; eu1_pc_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
      out_valid_q <= out_valid_d;
      eu0_en_q <= eu0_en_d;  eu1_en_q <= eu1_en_d;
      eu0_we_q <= eu0_we_d;  eu1_we_q <= eu1_we_d;
      eu0_rj_q <= eu0_rj_d;  eu0_rk_q <= eu0_rk_d;  eu0_rd_q <= eu0_rd_d;
      eu1_rj_q <= eu1_rj_d;  eu1_rk_q <= eu1_rk_d;  eu1_rd_q <= eu1_rd_d;
      data00_q <= data00_d;  data01_q <= data01_d;
      data10_q <= data10_d;  data11_q <= data11_d;
      eu0_pc_q <= eu0_pc_d;  eu1_pc_q <= eu1_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign eu0_en = eu0_en_q;  assign eu1_en = eu1_en_q;
  assign eu0_we = eu0_we_q;  assign eu1_we = eu1_we_q;
  assign eu0_rj = eu0_rj_q;  assign eu0_rk = eu0_rk_q;  assign eu0_rd = eu0_rd_q;
  assign eu1_rj = eu1_rj_q;  assign eu1_rk = eu1_rk_q;  assign eu1_rd = eu1_rd_q;
  assign data00 = data00_q;  assign data01 = data01_q;
  assign data10 = data10_q;  assign data11 = data11_q;
  assign eu0_pc = eu0_pc_q;  assign eu1_pc = eu1_pc_q;

endmodule
